iter_div_unit: RTL and testbench

- Multi-cycle radix-2 restoring integer divider. It is the responder side of the divide handshake driven by the execute stages (start/op/operands in, quotient/remainder/done out).
- Serves div.w, mod.w, div.wu and mod.wu. The execute stage holds start high and stalls the pipeline until done is seen, then drops start in the done cycle.
- One instance per execute pipe.

---
 rtl/iter_div_unit.sv | 150 +++++++++++++++
 tb/tb_iter_div_unit.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/iter_div_unit.sv
// Multi-cycle radix-2 restoring divider for div.w/mod.w/div.wu/mod.wu.
// Operands are divided as magnitudes; sign correction is applied when results are registered.
//
// state  | meaning
// S_IDLE | waiting for start, operands latched on accept
// S_CALC | one restoring iteration per cycle, MSB first
// S_DONE | results valid, done pulse for this single cycle
module iter_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   input  logic             start,
   output logic [WIDTH-1:0] quotient_out,
   output logic [WIDTH-1:0] remainder_out,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state_q, state_d;
   logic             op_q, op_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] remo_q, remo_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] trial;
   logic             ge;
   logic [WIDTH-1:0] rem_nx;
   logic [WIDTH-1:0] quo_nx;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             div_zero;
   logic             ovf;

   // The remainder never exceeds the divisor, so a WIDTH-bit subtract is exact whenever it is kept.
   assign shifted = {rem_q, dvd_q[WIDTH-1]};
   assign ge      = shifted >= {1'b0, dvs_q};
   assign trial   = shifted[WIDTH-1:0] - dvs_q;
   assign rem_nx  = ge ? trial : shifted[WIDTH-1:0];
   assign quo_nx  = {dvd_q[WIDTH-2:0], ge};

   assign a_mag    = (op && dividend[WIDTH-1]) ? -dividend : dividend;
   assign b_mag    = (op && divisor[WIDTH-1])  ? -divisor  : divisor;
   assign div_zero = (divisor == '0);
   assign ovf      = op && (dividend == MIN_NEG) && (divisor == '1);

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      remo_d  = remo_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d   = op;
               qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
               rneg_d = dividend[WIDTH-1];
               dvd_d  = a_mag;
               dvs_d  = b_mag;
               rem_d  = '0;
               cnt_d  = '0;
               if (div_zero) begin
                  quot_d  = '1;
                  remo_d  = dividend;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else if (ovf) begin
                  quot_d  = MIN_NEG;
                  remo_d  = '0;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (!start) begin
               state_d = S_IDLE;
            end else begin
               rem_d = rem_nx;
               dvd_d = quo_nx;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CW'(WIDTH - 1)) begin
                  quot_d  = (op_q && qneg_q) ? -quo_nx : quo_nx;
                  remo_d  = (op_q && rneg_q) ? -rem_nx : rem_nx;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         remo_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         remo_q  <= remo_d;
         done_q  <= done_d;
      end
   end

   assign quotient_out  = quot_q;
   assign remainder_out = remo_q;
   assign done          = done_q;

endmodule

// File: tb/tb_iter_div_unit.sv
// Scoreboard bench for iter_div_unit: directed cases, abort, back-to-back, reset, random vs reference model.
module tb_iter_div_unit;
   localparam int W = 32;
   localparam logic [W-1:0] MIN_NEG = 32'h8000_0000;

   logic         clk = 1'b0;
   logic         rst, op, start;
   logic [W-1:0] dividend, divisor;
   logic [W-1:0] quotient_out, remainder_out;
   logic         done;

   iter_div_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .op(op), .dividend(dividend), .divisor(divisor),
      .start(start), .quotient_out(quotient_out), .remainder_out(remainder_out), .done(done)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      int unsigned  lat;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r, input int unsigned lat);
      exp_t e;
      e.q = q; e.r = r; e.lat = lat;
      return e;
   endfunction

   function automatic exp_t model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [W-1:0] sa, sb;
      exp_t e;
      sa = a; sb = b;
      e.lat = 33;
      if (b == '0) begin
         e.q = '1; e.r = a; e.lat = 1;
      end else if (o && a == MIN_NEG && b == '1) begin
         e.q = MIN_NEG; e.r = '0; e.lat = 1;
      end else if (o) begin
         e.q = sa / sb; e.r = sa % sb;
      end else begin
         e.q = a / b; e.r = a % b;
      end
      return e;
   endfunction

   // Drives one request, holds start until done, then compares against the scoreboard head.
   task automatic issue(input string tag, input logic o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input exp_t e, output int unsigned done_cyc);
      int unsigned n;
      exp_t ex;
      @(negedge clk);
      op = o; dividend = a; divisor = b; start = 1'b1;
      exp_q.push_back(e);
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < 40);
      start = 1'b0;
      done_cyc = cyc;
      ex = exp_q.pop_front();
      chk({tag, "_done_seen"}, done, 1'b1);
      chk({tag, "_latency"}, n, ex.lat);
      chk({tag, "_q"}, quotient_out, ex.q);
      chk({tag, "_r"}, remainder_out, ex.r);
   endtask

   initial begin
      int unsigned t1, t2, dcount;
      logic o;
      logic [W-1:0] a, b;

      rst = 1'b1; start = 1'b0; op = 1'b0; dividend = '0; divisor = '0;
      repeat (3) @(negedge clk);
      chk("rst_done", done, 1'b0);
      chk("rst_q", quotient_out, '0);
      chk("rst_r", remainder_out, '0);
      rst = 1'b0;

      issue("u_7_2", 1'b0, 32'd7, 32'd2, mk(32'h3, 32'h1, 33), t1);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      issue("u_fff9_2", 1'b0, 32'hFFFF_FFF9, 32'd2, mk(32'h7FFF_FFFC, 32'h1, 33), t1);
      issue("s_m7_2", 1'b1, -32'sd7, 32'd2, mk(32'hFFFF_FFFD, 32'hFFFF_FFFF, 33), t1);
      issue("s_7_m2", 1'b1, 32'd7, -32'sd2, mk(32'hFFFF_FFFD, 32'h1, 33), t1);
      issue("s_m7_m2", 1'b1, -32'sd7, -32'sd2, mk(32'h3, 32'hFFFF_FFFF, 33), t1);
      issue("u_div0", 1'b0, 32'h1234_5678, 32'h0, mk(32'hFFFF_FFFF, 32'h1234_5678, 1), t1);
      issue("s_div0", 1'b1, 32'h1234_5678, 32'h0, mk(32'hFFFF_FFFF, 32'h1234_5678, 1), t1);
      issue("s_ovf", 1'b1, MIN_NEG, 32'hFFFF_FFFF, mk(MIN_NEG, 32'h0, 1), t1);

      // abort: drop start in cycle 10 of a 100/7 operation
      @(negedge clk);
      op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk);
      repeat (10) @(negedge clk);
      start = 1'b0;
      dcount = 0;
      repeat (45) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk("abort_no_done", dcount, 0);
      chk("abort_q_held", quotient_out, MIN_NEG);
      chk("abort_r_held", remainder_out, 32'h0);
      issue("restart", 1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 33), t1);

      issue("b2b_1", 1'b0, 32'd100, 32'd7, mk(32'd14, 32'd2, 33), t1);
      issue("b2b_2", 1'b0, 32'hFFFF_FFFF, 32'h10, mk(32'h0FFF_FFFF, 32'hF, 33), t2);
      chk("b2b_gap", t2 - t1, 34);

      // reset in cycle 15 of a calculation
      @(negedge clk);
      op = 1'b1; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      @(posedge clk);
      repeat (15) @(negedge clk);
      rst = 1'b1; start = 1'b0;
      @(negedge clk);
      chk("midrst_done", done, 1'b0);
      chk("midrst_q", quotient_out, '0);
      chk("midrst_r", remainder_out, '0);
      rst = 1'b0;
      dcount = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk("midrst_no_done", dcount, 0);

      for (int i = 0; i < 1000; i++) begin
         o = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 5))
            0: a = MIN_NEG;
            1: a = '1;
            2: a = 32'($urandom_range(0, 15));
            default: a = $urandom;
         endcase
         case ($urandom_range(0, 6))
            0: b = MIN_NEG;
            1: b = '1;
            2: b = '0;
            3: b = 32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         issue("rand", o, a, b, model(o, a, b), t1);
      end

      chk("sb_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
